tdm_demux_1xn: RTL and testbench

TDM_DEMUX_1XN -- requirements
Module: tdm_demux_1xn

---
 rtl/tdm_pkg.sv | 13 +
 rtl/tdm_slot_counter.sv | 25 ++
 rtl/tdm_demux_1xn.sv | 98 +++++++++
 tb/tb_tdm_demux_1xn.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared TDM definitions: frame-side FSM states and default slot count,
// used by both the demux and the transmitting mux.
package tdm_pkg;

    localparam int TDM_N_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter for a TDM frame: start loads 1 (slot 0 already taken),
// inc advances, clr returns to 0; tc flags the last slot of the frame.
module tdm_slot_counter #(
    parameter int N = 16,
    localparam int SLOT_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              inc,
    input  logic              clr,
    output logic [SLOT_W-1:0] cnt,
    output logic              tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        cnt <= '0;
        else if (start) cnt <= SLOT_W'(1);
        else if (clr)   cnt <= '0;
        else if (inc)   cnt <= cnt + SLOT_W'(1);
    end

    assign tc = (cnt == SLOT_W'(N - 1));

endmodule

// File: rtl/tdm_demux_1xn.sv
// Serial-to-parallel TDM frame demux: collects N slot bits into a shadow and
// publishes completed frames. Define TDM_DEMUX_PARITY_EN for a trailing even-parity beat.
module tdm_demux_1xn
    import tdm_pkg::*;
#(
    parameter int N = TDM_N_DEFAULT,
    localparam int SLOT_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_valid,
    input  logic              frame_start,
    output logic [N-1:0]      frame_data,
    output logic              frame_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              busy,
    output logic [SLOT_W-1:0] slot
);

    tdm_state_e  state;
    logic [N-1:0] shadow, shadow_nxt;
    logic         start_beat, data_beat, tc;

    assign start_beat = din_valid & frame_start;
    assign data_beat  = din_valid & ~frame_start & (state == COLLECT);
    assign busy       = (state != IDLE);

    always_comb begin
        shadow_nxt       = shadow;
        shadow_nxt[slot] = din;
    end

    tdm_slot_counter #(.N(N)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .start (start_beat),
        .inc   (data_beat & ~tc),
        .clr   (data_beat & tc),
        .cnt   (slot),
        .tc    (tc)
    );

`ifndef TDM_DEMUX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            if (start_beat) begin
                // A start mid-frame aborts the partial frame; frame_data is untouched.
                if (state != IDLE) frame_err <= 1'b1;
                shadow <= {{(N-1){1'b0}}, din};
                state  <= COLLECT;
            end else if (din_valid) begin
                case (state)
                    COLLECT: begin
                        shadow <= shadow_nxt;
                        if (tc) begin
`ifdef TDM_DEMUX_PARITY_EN
                            state <= PARITY;
`else
                            frame_data  <= shadow_nxt;
                            frame_valid <= 1'b1;
                            state       <= IDLE;
`endif
                        end
                    end
`ifdef TDM_DEMUX_PARITY_EN
                    PARITY: begin
                        frame_data  <= shadow;
                        frame_valid <= 1'b1;
                        parity_err  <= (^shadow) ^ din;
                        state       <= IDLE;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_1xn.sv
// Directed bench for tdm_demux_1xn (N=16): frame table plus back-to-back,
// abort, mid-frame reset and (with TDM_DEMUX_PARITY_EN) parity sequences.
module tb_tdm_demux_1xn;

    localparam int N = 16;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int FL = N + 1;
`else
    localparam int FL = N;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din = 1'b0, din_valid = 1'b0, frame_start = 1'b0;
    logic [N-1:0]  frame_data;
    logic          frame_valid, frame_err, parity_err, busy;
    logic [3:0]    slot;

    tdm_demux_1xn #(.N(N)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .frame_start(frame_start), .frame_data(frame_data),
        .frame_valid(frame_valid), .frame_err(frame_err),
        .parity_err(parity_err), .busy(busy), .slot(slot)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [N-1:0] data; logic perr; } pulse_t;
    typedef struct { logic [N-1:0] data; bit gapped; logic [N-1:0] exp; } vec_t;

    pulse_t pq[$];
    int cyc = 0, last_beat = 0, err_cnt = 0;
    int tests = 0, fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) pq.push_back('{cyc, frame_data, parity_err});
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic beat(input logic v, input logic fs, input logic d);
        @(negedge clk);
        din_valid = v; frame_start = fs; din = d;
        if (v) last_beat = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0);
    endtask

    // Sends bits first..N-1 LSB-first (frame_start on bit 0), then a correct parity beat if enabled.
    task automatic send(input logic [N-1:0] data, input bit gapped, input int first);
        for (int i = first; i < N; i++) begin
            beat(1'b1, i == 0, data[i]);
            if (gapped && i < N - 1) beat(1'b0, 1'b0, 1'b0);
        end
`ifdef TDM_DEMUX_PARITY_EN
        if (gapped) beat(1'b0, 1'b0, 1'b0);
        beat(1'b1, 1'b0, ^data);
`endif
    endtask

    task automatic chk_pulse(input string nm, input logic [N-1:0] exp, input int exp_cyc,
                             input logic exp_perr);
        chk({nm, " pulses"}, 64'(pq.size()), 64'd1);
        if (pq.size() > 0) begin
            chk({nm, " data"}, 64'(pq[0].data), 64'(exp));
            chk({nm, " latency"}, 64'(pq[0].cyc), 64'(exp_cyc));
            chk({nm, " perr"}, 64'(pq[0].perr), 64'(exp_perr));
        end
    endtask

    vec_t vecs[5];
    int   first_last;

    initial begin
        vecs[0] = '{16'hA5C3, 1'b0, 16'hA5C3};
        vecs[1] = '{16'h1234, 1'b1, 16'h1234};
        vecs[2] = '{16'h0000, 1'b0, 16'h0000};
        vecs[3] = '{16'hFFFF, 1'b1, 16'hFFFF};
        vecs[4] = '{16'h8001, 1'b0, 16'h8001};

        // reset state
        #12;
        chk("rst frame_data", 64'(frame_data), 64'd0);
        chk("rst frame_valid", 64'(frame_valid), 64'd0);
        chk("rst frame_err", 64'(frame_err), 64'd0);
        chk("rst parity_err", 64'(parity_err), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst slot", 64'(slot), 64'd0);
        @(negedge clk); rst = 1'b0;
        idle(2);

        // idle beats without frame_start are ignored
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b0, 1'b0, 1'b0);
        chk("idle ignore slot", 64'(slot), 64'd0);
        chk("idle ignore busy", 64'(busy), 64'd0);

        for (int v = 0; v < 5; v++) begin
            pq.delete(); err_cnt = 0;
            send(vecs[v].data, vecs[v].gapped, 0);
            idle(3);
            chk_pulse($sformatf("vec%0d", v), vecs[v].exp, last_beat, 1'b0);
            chk($sformatf("vec%0d err", v), 64'(err_cnt), 64'd0);
            chk($sformatf("vec%0d hold", v), 64'(frame_data), 64'(vecs[v].exp));
            chk($sformatf("vec%0d slot", v), 64'(slot), 64'd0);
        end

        // back-to-back frames with zero gap
        pq.delete(); err_cnt = 0;
        send(16'h0001, 1'b0, 0);
        first_last = last_beat;
        send(16'hFFFF, 1'b0, 0);
        idle(3);
        chk("b2b pulses", 64'(pq.size()), 64'd2);
        if (pq.size() == 2) begin
            chk("b2b first data", 64'(pq[0].data), 64'h0001);
            chk("b2b first latency", 64'(pq[0].cyc), 64'(first_last));
            chk("b2b second data", 64'(pq[1].data), 64'hFFFF);
            chk("b2b spacing", 64'(pq[1].cyc - pq[0].cyc), 64'(FL));
        end
        chk("b2b err", 64'(err_cnt), 64'd0);

        // frame_start at slot 9 aborts, then a full 0x00FF frame
        pq.delete(); err_cnt = 0;
        for (int i = 0; i < 9; i++) beat(1'b1, i == 0, 1'b1);
        beat(1'b0, 1'b0, 1'b0);
        chk("abort busy", 64'(busy), 64'd1);
        chk("abort slot pre", 64'(slot), 64'd9);
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b0, 1'b0, 1'b0);
        chk("abort err pulse", 64'(frame_err), 64'd1);
        chk("abort data kept", 64'(frame_data), 64'hFFFF);
        chk("abort slot post", 64'(slot), 64'd1);
        send(16'h00FF, 1'b0, 1);
        idle(3);
        chk_pulse("abort frame", 16'h00FF, last_beat, 1'b0);
        chk("abort err count", 64'(err_cnt), 64'd1);

        // reset after 7 bits, then a full 0xBEEF frame
        pq.delete(); err_cnt = 0;
        for (int i = 0; i < 7; i++) beat(1'b1, i == 0, 1'b0);
        beat(1'b0, 1'b0, 1'b0);
        chk("mid slot", 64'(slot), 64'd7);
        #2 rst = 1'b1;
        #1;
        chk("mid rst frame_data", 64'(frame_data), 64'd0);
        chk("mid rst busy", 64'(busy), 64'd0);
        chk("mid rst slot", 64'(slot), 64'd0);
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b0, 1'b0, 1'b0);
        chk("mid rst valid", 64'(frame_valid), 64'd0);
        chk("mid rst err", 64'(frame_err), 64'd0);
        chk("mid rst perr", 64'(parity_err), 64'd0);
        chk("mid rst hold slot", 64'(slot), 64'd0);
        @(negedge clk);
        rst = 1'b0; din_valid = 1'b1; frame_start = 1'b0; din = 1'b1;
        beat(1'b0, 1'b0, 1'b0);
        chk("post rst ignore slot", 64'(slot), 64'd0);
        chk("post rst ignore busy", 64'(busy), 64'd0);
        send(16'hBEEF, 1'b0, 0);
        idle(3);
        chk_pulse("post rst frame", 16'hBEEF, last_beat, 1'b0);
        chk("post rst err", 64'(err_cnt), 64'd0);

`ifdef TDM_DEMUX_PARITY_EN
        // 0x0003 has even data parity: parity bit 1 is a mismatch, 0 is clean
        for (int p = 1; p >= 0; p--) begin
            pq.delete(); err_cnt = 0;
            for (int i = 0; i < N; i++) beat(1'b1, i == 0, i < 2);
            beat(1'b0, 1'b0, 1'b0);
            chk($sformatf("par%0d busy", p), 64'(busy), 64'd1);
            chk($sformatf("par%0d no early valid", p), 64'(pq.size()), 64'd0);
            beat(1'b1, 1'b0, p[0]);
            idle(3);
            chk_pulse($sformatf("par%0d", p), 16'h0003, last_beat, p[0]);
            chk($sformatf("par%0d idle", p), 64'(busy), 64'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
